cpu_sequencer: RTL

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_pkg.sv | 62 ++++++
 rtl/cpu_sequencer_cond_eval.sv | 25 ++
 rtl/cpu_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU sequencer: instruction types, system sub-ops,
// jump condition codes, stack-pointer commands, FSM states and control bundle.
package cpu_pkg;

    typedef enum logic [1:0] {
        TYPE_ALU   = 2'b00,
        TYPE_PUSHI = 2'b01,
        TYPE_JUMP  = 2'b10,
        TYPE_SYS   = 2'b11
    } instrTypeT;

    typedef enum logic [1:0] {
        SYS_NOP  = 2'b00,
        SYS_DROP = 2'b01,
        SYS_DUP  = 2'b10,
        SYS_HALT = 2'b11
    } sysOpT;

    localparam logic [2:0] COND_ALWAYS = 3'b000;
    localparam logic [2:0] COND_Z      = 3'b001;
    localparam logic [2:0] COND_NZ     = 3'b010;
    localparam logic [2:0] COND_S      = 3'b011;
    localparam logic [2:0] COND_C      = 3'b100;
    localparam logic [2:0] COND_NC     = 3'b101;

    localparam logic [1:0] SP_HOLD = 2'b00;
    localparam logic [1:0] SP_INC  = 2'b01;
    localparam logic [1:0] SP_DEC  = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_EXEC  = 3'd1,
        ST_WB    = 3'd2,
        ST_HALT  = 3'd3,
        ST_FAULT = 3'd4
    } seqStateT;

    typedef struct packed {
        logic       ipW;
        logic       ipSel;
        logic       tW;
        logic       tSel;
        logic       rW;
        logic       rS;
        logic       stkW;
        logic       stkS;
        logic [1:0] spCtrl;
        logic [4:0] aluOp;
        logic       carryW;
        logic [1:0] jSel;
        logic       busy;
        logic       halt;
        logic       fault;
    } seqCtrlT;

    // Instructions that leave one more entry on the stack after WB.
    function automatic logic isPush(instrTypeT kind, logic [5:0] low);
        return (kind == TYPE_ALU && low[5]) || (kind == TYPE_PUSHI) ||
               (kind == TYPE_SYS && sysOpT'(low[1:0]) == SYS_DUP);
    endfunction

endpackage

// File: rtl/cpu_sequencer_cond_eval.sv
// Jump condition evaluator: condition code plus live flags -> taken.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       flagZero,
    input  logic       flagSign,
    input  logic       carry,
    output logic       taken_c
);

    always_comb begin
        taken_c = 1'b0;
        case (cond)
            COND_ALWAYS: taken_c = 1'b1;
            COND_Z:      taken_c = flagZero;
            COND_NZ:     taken_c = ~flagZero;
            COND_S:      taken_c = flagSign;
            COND_C:      taken_c = carry;
            COND_NC:     taken_c = ~carry;
            default:     taken_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Three-phase (FETCH/EXEC/WB) micro-sequencer for a small stack CPU.
// Define CPU_SEQ_STACK_GUARD_EN to add stack depth tracking with overflow/underflow fault.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned STACK_DEPTH    = 16,
    parameter int unsigned FETCH_WAIT_MAX = 4
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic [17:0] i_instr,
    input  logic        i_instr_valid,
    input  logic        i_flag_zero,
    input  logic        i_flag_sign,
    input  logic        i_carry,
    output logic        o_ip_w,
    output logic        o_ip_sel,
    output logic        o_t_w,
    output logic        o_t_sel,
    output logic        o_r_w,
    output logic        o_r_s,
    output logic        o_stk_w,
    output logic        o_stk_s,
    output logic [1:0]  o_sp_ctrl,
    output logic [4:0]  o_alu_op,
    output logic        o_carry_w,
    output logic [1:0]  o_j_sel,
    output logic        o_busy,
    output logic        o_halt,
    output logic        o_fault
);

    localparam int unsigned WAIT_W = $clog2(FETCH_WAIT_MAX + 1);

    if (STACK_DEPTH < 4 || STACK_DEPTH > 256 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : gBadStackDepth
        $error("cpu_sequencer: STACK_DEPTH must be a power of two in 4..256");
    end

    seqStateT          state, stateNext;
    instrTypeT         irKind, irKindNext;
    logic [5:0]        irLow, irLowNext;
    logic [WAIT_W-1:0] waitCnt, waitNext;
    seqCtrlT           ctrl, ctrlNext;
    logic              taken_c;
    logic              unusedPayload;

    // Payload bits above the opcode field travel to T over the datapath only.
    assign unusedPayload = ^i_instr[15:6];

`ifdef CPU_SEQ_STACK_GUARD_EN
    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH) + 1;

    logic [DEPTH_W-1:0] depth, depthNext;
    logic               stackFault_c;

    // Overflow on a push into a full stack; underflow on DROP or ALU with nothing stacked.
    assign stackFault_c =
        (isPush(irKind, irLow) && depth == DEPTH_W'(STACK_DEPTH)) ||
        (((irKind == TYPE_SYS && sysOpT'(irLow[1:0]) == SYS_DROP) || irKind == TYPE_ALU) &&
         depth == DEPTH_W'(0));
`endif

    cond_eval uCondEval (
        .cond     (irLow[2:0]),
        .flagZero (i_flag_zero),
        .flagSign (i_flag_sign),
        .carry    (i_carry),
        .taken_c  (taken_c)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= ST_FETCH;
            irKind  <= TYPE_ALU;
            irLow   <= '0;
            waitCnt <= '0;
            ctrl    <= '0;
`ifdef CPU_SEQ_STACK_GUARD_EN
            depth   <= '0;
`endif
        end else begin
            state   <= stateNext;
            irKind  <= irKindNext;
            irLow   <= irLowNext;
            waitCnt <= waitNext;
            ctrl    <= ctrlNext;
`ifdef CPU_SEQ_STACK_GUARD_EN
            depth   <= depthNext;
`endif
        end
    end

    // Next state, then the control word for the state being entered (outputs are registered).
    always_comb begin
        stateNext  = state;
        irKindNext = irKind;
        irLowNext  = irLow;
        waitNext   = waitCnt;
        ctrlNext   = '0;
`ifdef CPU_SEQ_STACK_GUARD_EN
        depthNext  = depth;
`endif

        case (state)
            ST_FETCH: begin
                if (i_instr_valid) begin
                    irKindNext = instrTypeT'(i_instr[17:16]);
                    irLowNext  = i_instr[5:0];
                    waitNext   = '0;
                    stateNext  = ST_EXEC;
                end else if (waitCnt == WAIT_W'(FETCH_WAIT_MAX - 1)) begin
                    stateNext = ST_FAULT;
                end else begin
                    waitNext = waitCnt + WAIT_W'(1);
                end
            end
            ST_EXEC: begin
                if (irKind == TYPE_SYS && sysOpT'(irLow[1:0]) == SYS_HALT) begin
                    stateNext = ST_HALT;
`ifdef CPU_SEQ_STACK_GUARD_EN
                end else if (stackFault_c) begin
                    stateNext = ST_FAULT;
`endif
                end else begin
                    stateNext = ST_WB;
                end
            end
            ST_WB: begin
                stateNext = ST_FETCH;
`ifdef CPU_SEQ_STACK_GUARD_EN
                if (isPush(irKind, irLow)) begin
                    depthNext = depth + DEPTH_W'(1);
                end else if (irKind == TYPE_SYS && sysOpT'(irLow[1:0]) == SYS_DROP) begin
                    depthNext = depth - DEPTH_W'(1);
                end
`endif
            end
            ST_HALT:  stateNext = ST_HALT;
            ST_FAULT: stateNext = ST_FAULT;
            default:  stateNext = ST_FETCH;
        endcase

        case (stateNext)
            ST_EXEC: begin
                ctrlNext.busy = 1'b1;
                case (irKindNext)
                    TYPE_ALU: begin
                        ctrlNext.aluOp  = irLowNext[4:0];
                        ctrlNext.rW     = 1'b1;
                        ctrlNext.carryW = 1'b1;
                    end
                    TYPE_PUSHI: begin
                        ctrlNext.tSel = 1'b1;
                        ctrlNext.tW   = 1'b1;
                    end
                    TYPE_JUMP: ctrlNext.jSel = irLowNext[4:3];
                    TYPE_SYS: begin
                        if (sysOpT'(irLowNext[1:0]) == SYS_DUP) begin
                            ctrlNext.stkS = 1'b1;
                            ctrlNext.tW   = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            ST_WB: begin
                ctrlNext.busy = 1'b1;
                ctrlNext.ipW  = 1'b1;
                case (irKindNext)
                    TYPE_ALU: begin
                        if (irLowNext[5]) begin
                            ctrlNext.rS     = 1'b1;
                            ctrlNext.stkW   = 1'b1;
                            ctrlNext.spCtrl = SP_INC;
                        end
                    end
                    TYPE_PUSHI: begin
                        ctrlNext.stkW   = 1'b1;
                        ctrlNext.spCtrl = SP_INC;
                    end
                    // The ipSel flop is the registered jump condition.
                    TYPE_JUMP: ctrlNext.ipSel = taken_c;
                    TYPE_SYS: begin
                        if (sysOpT'(irLowNext[1:0]) == SYS_DROP) begin
                            ctrlNext.spCtrl = SP_DEC;
                        end else if (sysOpT'(irLowNext[1:0]) == SYS_DUP) begin
                            ctrlNext.stkW   = 1'b1;
                            ctrlNext.spCtrl = SP_INC;
                        end
                    end
                    default: ;
                endcase
            end
            ST_HALT:  ctrlNext.halt  = 1'b1;
            ST_FAULT: ctrlNext.fault = 1'b1;
            default:  ;
        endcase
    end

    assign o_ip_w    = ctrl.ipW;
    assign o_ip_sel  = ctrl.ipSel;
    assign o_t_w     = ctrl.tW;
    assign o_t_sel   = ctrl.tSel;
    assign o_r_w     = ctrl.rW;
    assign o_r_s     = ctrl.rS;
    assign o_stk_w   = ctrl.stkW;
    assign o_stk_s   = ctrl.stkS;
    assign o_sp_ctrl = ctrl.spCtrl;
    assign o_alu_op  = ctrl.aluOp;
    assign o_carry_w = ctrl.carryW;
    assign o_j_sel   = ctrl.jSel;
    assign o_busy    = ctrl.busy;
    assign o_halt    = ctrl.halt;
    assign o_fault   = ctrl.fault;

endmodule
